minesweeper_sequencer: RTL and testbench



---
 rtl/minesweeper_pkg.sv | 34 +++
 rtl/minesweeper_sequencer_if.sv | 50 +++++
 rtl/seq_watchdog.sv | 34 +++
 rtl/minesweeper_sequencer.sv | 143 ++++++++++++++
 tb/tb_minesweeper_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_pkg
// Description : Shared state codes and board constants for the 3x3 minesweeper
//               game controller.
// Revision    : 1.0 - initial release
// ============================================================================
package minesweeper_pkg;

  localparam int         BOARD_CELLS   = 9;
  localparam int         CELL_W        = 4;
  localparam int         BOARD_W       = 9;
  localparam logic [8:0] ALL_SAFE_MASK = 9'h1FF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PLACE    = 4'd1,
    ST_WAITMOVE = 4'd2,
    ST_LOAD     = 4'd3,
    ST_DECODE   = 4'd4,
    ST_ALU      = 4'd5,
    ST_CHECK    = 4'd6,
    ST_GAMEOVER = 4'd7,
    ST_WIN      = 4'd8,
    ST_FAULT    = 4'd9
  } state_t;

  // States that wait on a unit's done and are guarded by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_PLACE) || (s == ST_DECODE) || (s == ST_ALU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/minesweeper_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_sequencer_if
// Description : User-request, datapath-handshake and status bundle of the
//               minesweeper game controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface minesweeper_sequencer_if;
  import minesweeper_pkg::*;

  logic                in_place;
  logic                in_data_in;
  logic [CELL_W-1:0]   in_data;
  logic                in_place_done;
  logic                in_decode_done;
  logic                in_alu_done;
  logic                in_hit;
  logic [BOARD_W-1:0]  in_mines;
  logic [BOARD_W-1:0]  in_cleared;

  logic [3:0]          out_state_main;
  logic                out_place_start;
  logic                out_load;
  logic                out_decode;
  logic                out_alu;
  logic [CELL_W-1:0]   out_temp_data_in;
  logic [3:0]          out_move_count;
  logic                out_error;
  logic                out_gameover;
  logic                out_win;
  logic                out_fault;

  modport master (
    output in_place, in_data_in, in_data, in_place_done, in_decode_done,
           in_alu_done, in_hit, in_mines, in_cleared,
    input  out_state_main, out_place_start, out_load, out_decode, out_alu,
           out_temp_data_in, out_move_count, out_error, out_gameover,
           out_win, out_fault
  );

  modport slave (
    input  in_place, in_data_in, in_data, in_place_done, in_decode_done,
           in_alu_done, in_hit, in_mines, in_cleared,
    output out_state_main, out_place_start, out_load, out_decode, out_alu,
           out_temp_data_in, out_move_count, out_error, out_gameover,
           out_win, out_fault
  );

endinterface
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Handshake watchdog; counts waiting cycles and flags expiry on
//               the last allowed cycle so the FSM can divert to FAULT.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_count <= 4'd0;
    end else if (i_enable) begin
      r_count <= r_count + 4'd1;
    end
  end

  // Count is 0 on the entry cycle, so TIMEOUT_CYCLES-1 marks the last waiting cycle.
  assign o_expired = i_enable && (r_count == 4'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/minesweeper_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : minesweeper_sequencer
// Description : Game controller sequencing placement, move load, decode and
//               ALU units; validates moves, counts them and resolves outcome.
// Revision    : 1.0 - initial release
// ============================================================================
module minesweeper_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int BOARD_CELLS    = 9
) (
  input  logic                    in_clka,
  input  logic                    in_restart,
  minesweeper_sequencer_if.slave  bus
);
  import minesweeper_pkg::*;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_temp, w_temp_nxt;
  logic [3:0]  r_move_count, w_count_nxt;
  logic        r_hit, w_hit_nxt;
  logic        r_error, w_error_nxt;
  logic        r_place_start, r_load, r_decode, r_alu;
  logic        r_gameover, r_win, r_fault;
  logic        w_place_start_nxt, w_load_nxt, w_decode_nxt, w_alu_nxt;
  logic [15:0] w_cleared_ext;
  logic        w_legal;
  logic        w_wd_clear, w_wd_enable, w_wd_expired;

  assign w_cleared_ext = 16'(bus.in_cleared);
  assign w_legal       = (bus.in_data < 4'(BOARD_CELLS)) && !w_cleared_ext[bus.in_data];

  always_comb begin
    w_state_nxt = r_state;
    w_temp_nxt  = r_temp;
    w_count_nxt = r_move_count;
    w_hit_nxt   = r_hit;
    w_error_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_place) w_state_nxt = ST_PLACE;
      end
      ST_PLACE: begin
        if (bus.in_place_done)  w_state_nxt = ST_WAITMOVE;
        else if (w_wd_expired)  w_state_nxt = ST_FAULT;
      end
      ST_WAITMOVE: begin
        if (bus.in_data_in) begin
          if (w_legal) begin
            w_temp_nxt  = bus.in_data;
            w_count_nxt = (r_move_count == 4'hF) ? r_move_count : r_move_count + 4'd1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (bus.in_decode_done) w_state_nxt = ST_ALU;
        else if (w_wd_expired)  w_state_nxt = ST_FAULT;
      end
      ST_ALU: begin
        if (bus.in_alu_done) begin
          w_hit_nxt   = bus.in_hit;
          w_state_nxt = ST_CHECK;
        end else if (w_wd_expired) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_CHECK: begin
        if (r_hit)                                                  w_state_nxt = ST_GAMEOVER;
        else if ((bus.in_cleared | bus.in_mines) == ALL_SAFE_MASK)  w_state_nxt = ST_WIN;
        else                                                        w_state_nxt = ST_WAITMOVE;
      end
      ST_GAMEOVER, ST_WIN, ST_FAULT: w_state_nxt = r_state;
      default: w_state_nxt = ST_FAULT;
    endcase
  end

  // Strobes fire only on the edge that enters their state.
  assign w_place_start_nxt = (w_state_nxt == ST_PLACE)  && (r_state != ST_PLACE);
  assign w_decode_nxt      = (w_state_nxt == ST_DECODE) && (r_state != ST_DECODE);
  assign w_alu_nxt         = (w_state_nxt == ST_ALU)    && (r_state != ST_ALU);
  assign w_load_nxt        = (w_state_nxt == ST_LOAD);

  assign w_wd_enable = is_wait_state(r_state);
  assign w_wd_clear  = w_place_start_nxt || w_decode_nxt || w_alu_nxt;

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (in_clka),
    .rst       (in_restart),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      r_state       <= ST_IDLE;
      r_temp        <= 4'd0;
      r_move_count  <= 4'd0;
      r_hit         <= 1'b0;
      r_error       <= 1'b0;
      r_place_start <= 1'b0;
      r_load        <= 1'b0;
      r_decode      <= 1'b0;
      r_alu         <= 1'b0;
      r_gameover    <= 1'b0;
      r_win         <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_temp        <= w_temp_nxt;
      r_move_count  <= w_count_nxt;
      r_hit         <= w_hit_nxt;
      r_error       <= w_error_nxt;
      r_place_start <= w_place_start_nxt;
      r_load        <= w_load_nxt;
      r_decode      <= w_decode_nxt;
      r_alu         <= w_alu_nxt;
      r_gameover    <= (w_state_nxt == ST_GAMEOVER);
      r_win         <= (w_state_nxt == ST_WIN);
      r_fault       <= (w_state_nxt == ST_FAULT);
    end
  end

  assign bus.out_state_main   = r_state;
  assign bus.out_place_start  = r_place_start;
  assign bus.out_load         = r_load;
  assign bus.out_decode       = r_decode;
  assign bus.out_alu          = r_alu;
  assign bus.out_temp_data_in = r_temp;
  assign bus.out_move_count   = r_move_count;
  assign bus.out_error        = r_error;
  assign bus.out_gameover     = r_gameover;
  assign bus.out_win          = r_win;
  assign bus.out_fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_minesweeper_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_minesweeper_sequencer
// Description : Directed self-checking bench for minesweeper_sequencer with a
//               cycle-level expectation model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minesweeper_sequencer;
  import minesweeper_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  minesweeper_sequencer_if bus();

  minesweeper_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .BOARD_CELLS    (9)
  ) dut (
    .in_clka    (clk),
    .in_restart (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int e_state, e_temp, e_cnt;
  bit e_ps, e_ld, e_dec, e_alu, e_err, e_go, e_win, e_fault;
  int m_moves;
  bit chk_en;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle from time zero the outputs are meaningful.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state",       int'(bus.out_state_main),   e_state);
      check("place_start", int'(bus.out_place_start),  int'(e_ps));
      check("load",        int'(bus.out_load),         int'(e_ld));
      check("decode",      int'(bus.out_decode),       int'(e_dec));
      check("alu",         int'(bus.out_alu),          int'(e_alu));
      check("temp_data",   int'(bus.out_temp_data_in), e_temp);
      check("move_count",  int'(bus.out_move_count),   e_cnt);
      check("error",       int'(bus.out_error),        int'(e_err));
      check("gameover",    int'(bus.out_gameover),     int'(e_go));
      check("win",         int'(bus.out_win),          int'(e_win));
      check("fault",       int'(bus.out_fault),        int'(e_fault));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input int s);
    e_state = s;
    e_ps = 0; e_ld = 0; e_dec = 0; e_alu = 0; e_err = 0;
    e_go = (s == 7); e_win = (s == 8); e_fault = (s == 9);
  endtask

  task automatic drive_idle();
    bus.in_place = 0; bus.in_data_in = 0;
    bus.in_place_done = 0; bus.in_decode_done = 0; bus.in_alu_done = 0;
    bus.in_hit = 0;
  endtask

  task automatic done_drive(input int code, input logic v);
    case (code)
      1:       bus.in_place_done  = v;
      4:       bus.in_decode_done = v;
      default: bus.in_alu_done    = v;
    endcase
  endtask

  // Called in the entry cycle of a waiting state; done at cycle index `delay`
  // (0 = strobe cycle). Without done, the 15th waiting cycle ends in FAULT.
  task automatic wait_unit(input int code, input int delay, output bit faulted);
    faulted = 0;
    for (int k = 0; k < TO; k++) begin
      done_drive(code, k >= delay);
      cyc();
      done_drive(code, 1'b0);
      if (k >= delay) return;
      if (k == TO - 1) begin
        faulted = 1;
        expect_state(9);
        return;
      end
      expect_state(code);
    end
  endtask

  task automatic restart();
    rst = 1;
    drive_idle();
    expect_state(0);
    e_temp = 0; e_cnt = 0; m_moves = 0;
    cyc();
    rst = 0;
  endtask

  task automatic start_game(input int place_delay);
    bit f;
    bus.in_place = 1; bus.in_data_in = 1; bus.in_data = 4'd3;
    cyc();
    bus.in_place = 0; bus.in_data_in = 0;
    expect_state(1); e_ps = 1;
    wait_unit(1, place_delay, f);
    if (!f) expect_state(2);
  endtask

  task automatic do_move(input int idx, input int dd, input int ad, input bit hit,
                         input logic [8:0] cl_after);
    bit legal, f;
    int nxt;
    legal = (idx < 9) && (((int'(bus.in_cleared) >> idx) & 1) == 0);
    bus.in_data = 4'(idx); bus.in_data_in = 1;
    cyc();
    bus.in_data_in = 0;
    if (!legal) begin
      expect_state(2); e_err = 1;
      return;
    end
    if (m_moves < 15) m_moves++;
    e_cnt = m_moves; e_temp = idx;
    expect_state(3); e_ld = 1;
    bus.in_cleared = cl_after;
    cyc();
    expect_state(4); e_dec = 1; bus.in_hit = ~hit;
    wait_unit(4, dd, f);
    if (f) return;
    expect_state(5); e_alu = 1; bus.in_hit = hit;
    wait_unit(5, ad, f);
    if (f) return;
    expect_state(6); bus.in_hit = ~hit;
    cyc();
    if (hit)                                                  nxt = 7;
    else if ((bus.in_cleared | bus.in_mines) == ALL_SAFE_MASK) nxt = 8;
    else                                                      nxt = 2;
    expect_state(nxt);
    bus.in_hit = 0;
  endtask

  task automatic poke_terminal(input int s, input int n);
    repeat (n) begin
      bus.in_place = 1; bus.in_data_in = 1; bus.in_data = 4'd4;
      bus.in_place_done = 1; bus.in_decode_done = 1; bus.in_alu_done = 1; bus.in_hit = 1;
      cyc();
      expect_state(s);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    bus.in_data = 0; bus.in_mines = 9'h000; bus.in_cleared = 9'h000;
    expect_state(0); e_temp = 0; e_cnt = 0; m_moves = 0;
    chk_en = 1;
    repeat (3) cyc();
    check("lit_reset_state", int'(bus.out_state_main), 0);
    rst = 0;

    // Moves in IDLE are ignored.
    bus.in_data_in = 1; bus.in_data = 4'd1;
    cyc();
    bus.in_data_in = 0;
    expect_state(0);

    // Placement with done two cycles after the strobe.
    start_game(2);
    check("lit_wait_state", int'(bus.out_state_main), 2);

    // Stray dones while waiting for a move are ignored.
    bus.in_place_done = 1; bus.in_decode_done = 1; bus.in_alu_done = 1;
    cyc();
    drive_idle();
    expect_state(2);

    bus.in_mines = 9'h001;
    do_move(2, 0, 0, 0, 9'h004);
    check("lit_cnt_first", int'(bus.out_move_count), 1);
    check("lit_temp_first", int'(bus.out_temp_data_in), 2);

    do_move(9, 0, 0, 0, 9'h000);
    check("lit_err_idx9", int'(bus.out_error), 1);
    do_move(2, 0, 0, 0, 9'h000);
    check("lit_err_cleared", int'(bus.out_error), 1);
    do_move(15, 0, 0, 0, 9'h000);
    cyc();
    expect_state(2);
    check("lit_cnt_after_illegal", int'(bus.out_move_count), 1);

    // Highest cell, slow decode, ALU done on the last watchdog cycle.
    do_move(8, 3, 14, 0, 9'h104);
    check("lit_cnt_second", int'(bus.out_move_count), 2);

    do_move(0, 1, 2, 1, 9'h105);
    check("lit_gameover_state", int'(bus.out_state_main), 7);
    check("lit_gameover_flag", int'(bus.out_gameover), 1);
    poke_terminal(7, 4);
    check("lit_gameover_cnt", int'(bus.out_move_count), 3);

    restart();
    check("lit_restart_state", int'(bus.out_state_main), 0);

    // Winning game.
    bus.in_cleared = 9'h000; bus.in_mines = 9'h001;
    cyc();
    expect_state(0);
    start_game(0);
    do_move(5, 0, 0, 0, 9'h020);
    do_move(3, 2, 1, 0, 9'h1FE);
    check("lit_win_state", int'(bus.out_state_main), 8);
    check("lit_win_flag", int'(bus.out_win), 1);
    poke_terminal(8, 3);

    restart();

    // Counter saturation, placement done on the last watchdog cycle.
    bus.in_cleared = 9'h000;
    start_game(14);
    for (int i = 0; i < 16; i++) do_move(1, 0, 0, 0, 9'h000);
    check("lit_cnt_saturated", int'(bus.out_move_count), 15);

    // Decode never completes.
    do_move(1, 99, 0, 0, 9'h000);
    check("lit_fault_state", int'(bus.out_state_main), 9);
    check("lit_fault_flag", int'(bus.out_fault), 1);
    poke_terminal(9, 2);

    restart();

    // Restart in the middle of a decode wait.
    start_game(0);
    bus.in_data = 4'd6; bus.in_data_in = 1;
    cyc();
    bus.in_data_in = 0;
    m_moves = 1; e_cnt = 1; e_temp = 6;
    expect_state(3); e_ld = 1;
    cyc();
    expect_state(4); e_dec = 1;
    repeat (5) begin
      cyc();
      expect_state(4);
    end
    restart();
    check("lit_midrst_state", int'(bus.out_state_main), 0);
    check("lit_midrst_cnt", int'(bus.out_move_count), 0);
    check("lit_midrst_temp", int'(bus.out_temp_data_in), 0);

    // ALU never completes.
    start_game(1);
    do_move(7, 0, 99, 0, 9'h080);
    check("lit_alu_fault", int'(bus.out_state_main), 9);

    restart();
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
